maxpool2_relu: RTL
==================

// Module: maxpool2_relu
// PURPOSE
// - 2x2 stride-2 signed max-pool plus ReLU over three channels. Sits directly downstream of the
//   layer-2 depthwise conv; consumes its raster-order dep_out_1..3 stream.
// - Emits a half-resolution map per channel to the next (pointwise/dense) stage.
// - One input beat = one pixel of all three channels; no backpressure.
// PARAMETERS
// - DATA_W  15  sample width; input and output are two's-complement signed.
// - IMG_W   8   input columns per row. Must be even and >=2.
// - IMG_H   8   input rows per frame. Must be even and >=2.
// PORTS
// - clk          in   1       single clock, rising edge
// - rst          in   1       synchronous reset, active-high
// - in_valid     in   1       input pixel present this cycle (every high cycle = one pixel)
// - in_ch1..3    in   DATA_W  channel samples, signed
// - pool_out_1..3 out  DATA_W  pooled+ReLU result, always >=0
// - valid_out_pool out 1      1-cycle pulse: pool_out_* valid
// - frame_done   out  1       1-cycle pulse coincident with last pooled output of a frame
// BEHAVIOUR
// - Reset: every output and internal register goes to 0: pool_out_*, valid_out_pool, frame_done,
//   col/row counters, horizontal-max regs and line buffer. Reset mid-frame discards the partial
//   frame. The first in_valid after reset is pixel (row 0, col 0).
// - Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid.
//   - col wraps to 0 and increments row.
//   - Row wraps to 0 after (IMG_H-1, IMG_W-1), so the next frame starts seamlessly.
// - Idle cycles (in_valid=0) change no state except valid_out_pool and frame_done, which fall to 0.
// - Datapath per channel:
//   - Even col: hreg <= x.
//   - Odd col: h = max(hreg, x).
//     - Even row: linebuf[col>>1] <= h.
//     - Odd row: m = max(linebuf[col>>1], h); pool_out <= (m<0) ? 0 : m.
// - All comparisons are signed. There is no width growth, no rounding and no saturation.
//   ReLU is applied after the max, so a window that is entirely negative yields 0.
// - Latency: valid_out_pool is high exactly one cycle after the in_valid of each (odd row, odd col)
//   pixel. It is low at all other times.
// - Output count: (IMG_W/2)*(IMG_H/2) pulses per frame, in raster order.
// - frame_done is high in the same cycle as the last pooled output of a frame.
// - pool_out_* hold their value between pulses.
// - linebuf depth is IMG_W/2 per channel.
//   - An entry is written on the even row and read on the following odd row before it is
//     overwritten. This gives no read/write hazard.
//   - Back-to-back in_valid at full rate is supported.
// - in_valid may be continuous or gapped arbitrarily; the result must be identical.
// STRUCTURE
// - Shared package cnn_pkg: DATA_W, the layer-2 geometry constants (IMG_W=8, IMG_H=8) and the
//   NUM_CH=3 constant.
// - One sub-module, pool_ch:
//   - One channel's hreg, linebuf and max/ReLU logic, instantiated 3x.
//   - The top owns the shared col/row counters, the valid pipeline and frame_done.
// TESTING
// - Reset then 64 beats of ch1=row*8+col: 16 pulses.
//   - First pool_out_1=9 (max of 0,1,8,9).
//   - Last pool_out_1=63; frame_done with the 16th pulse.
// - All inputs -5 for a full frame: 16 pulses, all outputs 0 (ReLU of all-negative window).
// - One 2x2 window with samples {-16384, 16383, -1, 0} on ch2: pool_out_2=16383.
//   This checks the signed compare at the extremes.
// - Same frame as test 1, with in_valid deasserted for 3 cycles after every 5th beat:
//   - outputs are bit-identical to test 1;
//   - each pulse arrives 1 cycle after its odd/odd pixel.
// - Assert rst at beat 20, then stream a fresh 64-beat frame:
//   - no pulse before the new frame's pixel (1,1);
//   - the output matches a clean frame.
// - Two back-to-back frames with no gap: 32 pulses, two frame_done pulses.
//   The second frame's first output depends only on second-frame pixels.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cnn_pkg
//  Shared sample width, layer-2 geometry and channel count for the CNN
//  post-processing blocks (max-pool / ReLU and friends).
//  Revision: 1.0  initial release
// ============================================================================
package cnn_pkg;

  localparam int DATA_W = 15;  // signed sample width
  localparam int IMG_W  = 8;   // layer-2 input columns per row
  localparam int IMG_H  = 8;   // layer-2 input rows per frame
  localparam int NUM_CH = 3;   // channels carried per input beat

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/maxpool2_relu_pool_ch.sv
`default_nettype none
// ============================================================================
//  Module  : pool_ch
//  One channel of the 2x2 stride-2 signed max-pool with ReLU. Holds the
//  horizontal-max register, a half-width line buffer and the output register.
//  Column/row position is supplied by the parent, which owns the counters.
//  Revision: 1.0  initial release
//
//  Ports:
//    clk       in   1          clock, rising edge
//    rst       in   1          synchronous reset, active-high
//    in_valid  in   1          a pixel is present this cycle
//    col_odd   in   1          current pixel sits in an odd column
//    row_odd   in   1          current pixel sits in an odd row
//    half_col  in   HALF_W     column index >> 1 (line-buffer address)
//    x         in   DATA_W     signed sample
//    pool_out  out  DATA_W     pooled + ReLU result (held between updates)
// ============================================================================
module pool_ch #(
  parameter int DATA_W   = 15,
  parameter int LB_DEPTH = 4,
  parameter int HALF_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     col_odd,
  input  logic                     row_odd,
  input  logic [HALF_W-1:0]        half_col,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] pool_out
);

  logic signed [DATA_W-1:0] hreg_q, hreg_d;
  logic signed [DATA_W-1:0] linebuf_q [LB_DEPTH];
  logic signed [DATA_W-1:0] linebuf_d [LB_DEPTH];
  logic signed [DATA_W-1:0] pool_q, pool_d;
  logic signed [DATA_W-1:0] h_max;    // max of the horizontal pair
  logic signed [DATA_W-1:0] win_max;  // max of the full 2x2 window

  always_comb begin
    hreg_d    = hreg_q;
    linebuf_d = linebuf_q;
    pool_d    = pool_q;
    h_max     = (hreg_q > x) ? hreg_q : x;
    win_max   = (linebuf_q[half_col] > h_max) ? linebuf_q[half_col] : h_max;
    if (in_valid) begin
      if (!col_odd) begin
        hreg_d = x;
      end else if (!row_odd) begin
        // Upper half of the window parks here until the odd row reads it.
        linebuf_d[half_col] = h_max;
      end else begin
        // ReLU after the max: a negative window max clamps to zero.
        pool_d = win_max[DATA_W-1] ? '0 : win_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hreg_q <= '0;
      pool_q <= '0;
      for (int i = 0; i < LB_DEPTH; i++) begin
        linebuf_q[i] <= '0;
      end
    end else begin
      hreg_q    <= hreg_d;
      linebuf_q <= linebuf_d;
      pool_q    <= pool_d;
    end
  end

  assign pool_out = pool_q;

endmodule : pool_ch
`default_nettype wire

// File: rtl/maxpool2_relu.sv
`default_nettype none
// ============================================================================
//  Module  : maxpool2_relu
//  2x2 stride-2 signed max-pool followed by ReLU over three channels of a
//  raster-order pixel stream. No backpressure; input may be gapped freely.
//  Revision: 1.0  initial release
//
//  Ports:
//    clk             in   1       clock, rising edge
//    rst             in   1       synchronous reset, active-high
//    in_valid        in   1       one pixel of all channels this cycle
//    in_ch1..3       in   DATA_W  signed channel samples
//    pool_out_1..3   out  DATA_W  pooled + ReLU results, always >= 0
//    valid_out_pool  out  1       one-cycle pulse: pool_out_* updated
//    frame_done      out  1       pulse with the last pooled output of a frame
// ============================================================================
module maxpool2_relu #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_ch1,
  input  logic signed [DATA_W-1:0] in_ch2,
  input  logic signed [DATA_W-1:0] in_ch3,
  output logic signed [DATA_W-1:0] pool_out_1,
  output logic signed [DATA_W-1:0] pool_out_2,
  output logic signed [DATA_W-1:0] pool_out_3,
  output logic                     valid_out_pool,
  output logic                     frame_done
);

  import cnn_pkg::*;

  localparam int COL_W    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int HALF_W   = (LB_DEPTH > 2) ? $clog2(LB_DEPTH) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             col_last, row_last;
  logic [HALF_W-1:0] half_col;

  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign half_col = HALF_W'(col_q >> 1);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (in_valid) begin
      // The odd/odd pixel closes a window; its result lands next cycle.
      valid_d = col_q[0] & row_q[0];
      done_d  = col_last & row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  logic signed [DATA_W-1:0] ch_in  [NUM_CH];
  logic signed [DATA_W-1:0] ch_out [NUM_CH];

  assign ch_in[0] = in_ch1;
  assign ch_in[1] = in_ch2;
  assign ch_in[2] = in_ch3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pool_ch #(
      .DATA_W  (DATA_W),
      .LB_DEPTH(LB_DEPTH),
      .HALF_W  (HALF_W)
    ) u_pool_ch (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .col_odd (col_q[0]),
      .row_odd (row_q[0]),
      .half_col(half_col),
      .x       (ch_in[g]),
      .pool_out(ch_out[g])
    );
  end

  assign pool_out_1     = ch_out[0];
  assign pool_out_2     = ch_out[1];
  assign pool_out_3     = ch_out[2];
  assign valid_out_pool = valid_q;
  assign frame_done     = done_q;

endmodule : maxpool2_relu
`default_nettype wire
